// File: rtl/tx_pkg.sv
// Shared types and constants for the transmit framer / PSK mapper.
// The TX_SCRAMBLER_EN build uses the LFSR helpers below.
package tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SYNC,
    ST_PAYLOAD,
    ST_TAIL
  } tx_state_t;

  localparam logic [15:0] SYNC_WORD   = 16'hF3A5;
  localparam logic [7:0]  FILLER_BYTE = 8'h55;

  // x^7 + x^4 + 1: feedback taken from register bits 6 and 3
  localparam logic [6:0]  LFSR_SEED   = 7'h7F;
  localparam logic [6:0]  LFSR_TAPS   = 7'h48;

  localparam logic MODE_BPSK = 1'b0;
  localparam logic MODE_QPSK = 1'b1;

  function automatic logic lfsr_out(input logic [6:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

  function automatic logic [6:0] lfsr_step(input logic [6:0] s);
    return {s[5:0], lfsr_out(s)};
  endfunction

endpackage

// File: rtl/tx_frame_modulator_mapper.sv
// Combinational BPSK / Gray-QPSK symbol mapper to signed 12-bit I/Q.
module tx_symbol_mapper
  import tx_pkg::*;
#(
  parameter logic signed [11:0] AMP_BPSK = 12'sd2000,
  parameter logic signed [11:0] AMP_QPSK = 12'sd1414
) (
  input  logic               mode,
  input  logic               bit_hi,
  input  logic               bit_lo,
  input  logic               zero,
  output logic signed [11:0] sym_i,
  output logic signed [11:0] sym_q
);

  always_comb begin
    sym_i = '0;
    sym_q = '0;
    if (!zero) begin
      if (mode == MODE_QPSK) begin
        sym_i = bit_hi ? AMP_QPSK : -AMP_QPSK;
        sym_q = bit_lo ? AMP_QPSK : -AMP_QPSK;
      end else begin
        sym_i = bit_hi ? AMP_BPSK : -AMP_BPSK;
      end
    end
  end

endmodule

// File: rtl/tx_frame_modulator.sv
// Framer (preamble, sync, payload, tail) and symbol-rate PSK modulator.
// Optional payload scrambling is built when TX_SCRAMBLER_EN is defined.
module tx_frame_modulator
  import tx_pkg::*;
#(
  parameter int                 SYM_DIV       = 16,
  parameter int                 PREAMBLE_BITS = 32,
  parameter int                 TAIL_SYMS     = 8,
  parameter logic signed [11:0] AMP_BPSK      = 12'sd2000,
  parameter logic signed [11:0] AMP_QPSK      = 12'sd1414
) (
  input  logic               clk_16M384,
  input  logic               rst_16M384,
  input  logic [3:0]         MODE_CTRL,
  input  logic [7:0]         s_tdata,
  input  logic               s_tvalid,
  input  logic               s_tlast,
  output logic               s_tready,
  output logic signed [11:0] TX_I,
  output logic signed [11:0] TX_Q,
  output logic               sym_strobe,
  output logic               Tx_1bit,
  output logic               Tx_busy,
  output logic               frame_done,
  output logic               underrun
);

  localparam int DIV_W = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
  localparam int CNT_W = 8;

  logic [DIV_W-1:0]   div;
  logic               tick;
  tx_state_t          state, nxt_state;
  logic [CNT_W-1:0]   cnt, nxt_cnt;
  logic [CNT_W-1:0]   pre_last, sync_last, byte_last, tail_last;
  logic [CNT_W:0]     sync_shamt;
  logic [15:0]        sync_sh;
  logic               frame_mode, mode;
  logic               hold_full, hold_last;
  logic [7:0]         hold_data;
  logic [7:0]         sreg, src, nxt_sreg;
  logic               sreg_last;
  logic               load, done, zero, raw_hi, raw_lo, pay_sym;
  logic               scr_hi, scr_lo, b_hi, b_lo;
  logic               accept;
  logic signed [11:0] map_i, map_q;
  logic               unused_mode;

  assign unused_mode = ^MODE_CTRL[3:1];

  assign tick     = (div == DIV_W'(SYM_DIV - 1));
  // Mode is sampled live only while idle, so the first preamble symbol already uses it
  assign mode     = (state == ST_IDLE) ? MODE_CTRL[0] : frame_mode;
  assign s_tready = !hold_full && (state != ST_TAIL);
  assign accept   = s_tvalid && s_tready;

  assign pre_last  = (mode == MODE_QPSK) ? CNT_W'(PREAMBLE_BITS / 2 - 1) : CNT_W'(PREAMBLE_BITS - 1);
  assign sync_last = (mode == MODE_QPSK) ? CNT_W'(7) : CNT_W'(15);
  assign byte_last = (mode == MODE_QPSK) ? CNT_W'(3) : CNT_W'(7);
  assign tail_last = CNT_W'(TAIL_SYMS - 1);

  always_comb begin
    nxt_state  = state;
    nxt_cnt    = cnt + 1'b1;
    load       = 1'b0;
    done       = 1'b0;
    raw_hi     = 1'b0;
    raw_lo     = 1'b0;
    zero       = 1'b1;
    case (state)
      ST_IDLE: begin
        nxt_cnt = '0;
        if (hold_full) nxt_state = ST_PREAMBLE;
      end
      ST_PREAMBLE: if (cnt == pre_last) begin
        nxt_state = ST_SYNC;
        nxt_cnt   = '0;
      end
      ST_SYNC: if (cnt == sync_last) begin
        nxt_state = ST_PAYLOAD;
        nxt_cnt   = '0;
        load      = 1'b1;
      end
      ST_PAYLOAD: if (cnt == byte_last) begin
        nxt_cnt = '0;
        if (sreg_last) nxt_state = ST_TAIL;
        else           load      = 1'b1;
      end
      ST_TAIL: if (cnt == tail_last) begin
        nxt_state = ST_IDLE;
        nxt_cnt   = '0;
        done      = 1'b1;
      end
      default: begin
        nxt_state = ST_IDLE;
        nxt_cnt   = '0;
      end
    endcase

    // Symbol for the period that starts at this tick
    src        = load ? (hold_full ? hold_data : FILLER_BYTE) : sreg;
    nxt_sreg   = (mode == MODE_QPSK) ? {src[5:0], 2'b00} : {src[6:0], 1'b0};
    sync_shamt = (mode == MODE_QPSK) ? {nxt_cnt, 1'b0} : {1'b0, nxt_cnt};
    sync_sh    = SYNC_WORD << sync_shamt;
    case (nxt_state)
      ST_PREAMBLE: begin
        raw_hi = ~nxt_cnt[0];
        raw_lo = ~nxt_cnt[0];
        zero   = 1'b0;
      end
      ST_SYNC: begin
        raw_hi = sync_sh[15];
        raw_lo = sync_sh[14];
        zero   = 1'b0;
      end
      ST_PAYLOAD: begin
        raw_hi = src[7];
        raw_lo = src[6];
        zero   = 1'b0;
      end
      default: ;
    endcase
  end

  assign pay_sym = (nxt_state == ST_PAYLOAD);

`ifdef TX_SCRAMBLER_EN
  logic       seed;
  logic [6:0] lfsr, lfsr_cur, lfsr_mid, lfsr_nxt;

  assign seed     = (state == ST_SYNC) && (nxt_state == ST_PAYLOAD);
  assign lfsr_cur = seed ? LFSR_SEED : lfsr;
  assign lfsr_mid = lfsr_step(lfsr_cur);
  assign scr_hi   = lfsr_out(lfsr_cur);
  assign scr_lo   = (mode == MODE_QPSK) ? lfsr_out(lfsr_mid) : 1'b0;
  assign lfsr_nxt = (mode == MODE_QPSK) ? lfsr_step(lfsr_mid) : lfsr_mid;

  always_ff @(posedge clk_16M384 or negedge rst_16M384) begin
    if (!rst_16M384)               lfsr <= '0;
    else if (tick && pay_sym)      lfsr <= lfsr_nxt;
  end
`else
  assign scr_hi = 1'b0;
  assign scr_lo = 1'b0;
`endif

  assign b_hi = raw_hi ^ (scr_hi & pay_sym);
  assign b_lo = raw_lo ^ (scr_lo & pay_sym);

  tx_symbol_mapper #(
    .AMP_BPSK (AMP_BPSK),
    .AMP_QPSK (AMP_QPSK)
  ) u_mapper (
    .mode   (mode),
    .bit_hi (b_hi),
    .bit_lo (b_lo),
    .zero   (zero),
    .sym_i  (map_i),
    .sym_q  (map_q)
  );

  always_ff @(posedge clk_16M384 or negedge rst_16M384) begin
    if (!rst_16M384) begin
      div        <= '0;
      sym_strobe <= 1'b0;
      state      <= ST_IDLE;
      cnt        <= '0;
      frame_mode <= MODE_BPSK;
      hold_full  <= 1'b0;
      hold_last  <= 1'b0;
      sreg_last  <= 1'b0;
      TX_I       <= '0;
      TX_Q       <= '0;
      Tx_1bit    <= 1'b0;
      Tx_busy    <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      div        <= tick ? '0 : div + 1'b1;
      sym_strobe <= tick;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      if (accept) begin
        hold_full <= 1'b1;
        hold_last <= s_tlast;
      end else if (tick && load && hold_full) begin
        hold_full <= 1'b0;
      end
      if (tick) begin
        state      <= nxt_state;
        cnt        <= nxt_cnt;
        if (state == ST_IDLE) frame_mode <= MODE_CTRL[0];
        if (load) begin
          sreg_last <= hold_full & hold_last;
          underrun  <= !hold_full;
        end
        TX_I       <= map_i;
        TX_Q       <= map_q;
        Tx_1bit    <= b_hi & ~zero;
        Tx_busy    <= (nxt_state != ST_IDLE);
        frame_done <= done;
      end
    end
  end

  // Data-only registers: their contents are qualified by hold_full / state
  always_ff @(posedge clk_16M384) begin
    if (accept)             hold_data <= s_tdata;
    if (tick && pay_sym)    sreg      <= nxt_sreg;
  end

endmodule
